// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared types and constants for the trigger_multi slice
package trigger_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        EXPOSE = 2'd2
    } chan_state_t;

    localparam logic MODE_IMU  = 1'b0;
    localparam logic MODE_FREE = 1'b1;

    localparam int DEFAULT_CLK_PER_USEC = 125;

endpackage

// File: rtl/trigger_chan.sv
// rtl/trigger_chan.sv - one trigger/flash channel: shadow timing, FSM, usec and flash counters
module trigger_chan
    import trigger_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic             start,
    input  logic             tick,
    input  logic [CNT_W-1:0] delay_usec,
    input  logic [CNT_W-1:0] exposure_usec,
    input  logic [CNT_W-1:0] flash_usec,
    output logic             trigger,
    output logic             flash,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    chan_state_t      state;
    logic [CNT_W-1:0] delay_sh;
    logic [CNT_W-1:0] exposure_sh;
    logic [CNT_W-1:0] flash_sh;
    logic [CNT_W-1:0] usec_cnt;
    logic [CNT_W-1:0] flash_cnt;
    logic [CNT_W-1:0] flash_len;
    logic             enter_expose;
    logic             leave_expose;

    // A zero-delay start enters EXPOSE before the shadow is loaded, so use the live flash width then.
    assign flash_len = start ? flash_usec : flash_sh;
    assign busy      = (state != IDLE) | flash;

    always_comb begin
        enter_expose = 1'b0;
        leave_expose = 1'b0;
        case (state)
            IDLE:    enter_expose = start && (exposure_usec != '0) && (delay_usec == '0);
            DELAY:   enter_expose = tick && (usec_cnt >= delay_sh - ONE);
            EXPOSE:  leave_expose = tick && (usec_cnt >= exposure_sh - ONE);
            default: ;
        endcase
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            delay_sh    <= '0;
            exposure_sh <= '0;
            flash_sh    <= '0;
            usec_cnt    <= '0;
            trigger     <= 1'b0;
        end else begin
            if (start) begin
                delay_sh    <= delay_usec;
                exposure_sh <= exposure_usec;
                flash_sh    <= flash_usec;
            end
            case (state)
                IDLE: begin
                    if (start && (exposure_usec != '0)) begin
                        usec_cnt <= '0;
                        state    <= enter_expose ? EXPOSE : DELAY;
                    end
                end
                DELAY: begin
                    if (enter_expose) begin
                        state    <= EXPOSE;
                        usec_cnt <= '0;
                    end else if (tick) begin
                        usec_cnt <= usec_cnt + ONE;
                    end
                end
                EXPOSE: begin
                    if (leave_expose) begin
                        state    <= IDLE;
                        usec_cnt <= '0;
                    end else if (tick) begin
                        usec_cnt <= usec_cnt + ONE;
                    end
                end
                default: state <= IDLE;
            endcase
            trigger <= enter_expose | (trigger & ~leave_expose);
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            flash     <= 1'b0;
            flash_cnt <= '0;
        end else if (enter_expose) begin
            flash     <= (flash_len != '0);
            flash_cnt <= '0;
        end else if (flash && tick) begin
            if (flash_cnt >= flash_sh - ONE) begin
                flash <= 1'b0;
            end else begin
                flash_cnt <= flash_cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/trigger_multi.sv
// rtl/trigger_multi.sv - multi-channel camera trigger/flash generator with IMU-sync or free-run framing
module trigger_multi
    import trigger_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int CLK_PER_USEC = DEFAULT_CLK_PER_USEC,
    parameter int CNT_W        = 16,
    parameter int DECIM_W      = 8
) (
    input  logic                 c,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 mode,
    input  logic                 imu_sync,
    input  logic [DECIM_W-1:0]   imu_decim,
    input  logic [CNT_W-1:0]     free_period_usec,
    input  logic [NCH*CNT_W-1:0] delay_usec,
    input  logic [NCH*CNT_W-1:0] exposure_usec,
    input  logic [NCH*CNT_W-1:0] flash_usec,
    output logic [NCH-1:0]       trigger,
    output logic [NCH-1:0]       flash,
    output logic                 frame_start,
    output logic [15:0]          frame_cnt,
    output logic [7:0]           overrun_cnt,
    output logic                 busy
);

    localparam int PRE_W = (CLK_PER_USEC > 1) ? $clog2(CLK_PER_USEC) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(CLK_PER_USEC - 1);
    localparam logic [PRE_W-1:0]   PRE_ONE  = PRE_W'(1);
    localparam logic [DECIM_W-1:0] D_ONE    = DECIM_W'(1);
    localparam logic [CNT_W-1:0]   P_ONE    = CNT_W'(1);

    logic [PRE_W-1:0]   pre;
    logic [DECIM_W-1:0] dcnt;
    logic [CNT_W-1:0]   pcnt;
    logic               enable_q;
    logic               mode_q;
    logic               tick;
    logic               mode_chg;
    logic               period_end;
    logic               raw;
    logic               accept;
    logic               drop;
    logic [NCH-1:0]     chan_busy;

    assign tick       = (pre == PRE_LAST);
    assign mode_chg   = (mode != mode_q);
    assign period_end = (free_period_usec != '0) && (pcnt >= free_period_usec - P_ONE);

    // No raw event in the cycle the mode flips: the source counters are stale until cleared.
    assign raw = !mode_chg && enable &&
                 (((mode == MODE_IMU) && imu_sync && (dcnt == '0)) ||
                  ((mode == MODE_FREE) && tick && period_end));
    assign accept = raw && !busy;
    assign drop   = raw && busy;
    assign busy   = |chan_busy;

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            pre      <= '0;
            dcnt     <= '0;
            pcnt     <= '0;
            enable_q <= 1'b0;
            mode_q   <= MODE_IMU;
        end else begin
            enable_q <= enable;
            mode_q   <= mode;
            pre      <= (accept || tick) ? '0 : pre + PRE_ONE;
            if (mode_chg || (enable_q && !enable)) begin
                dcnt <= '0;
            end else if ((mode == MODE_IMU) && enable && imu_sync) begin
                dcnt <= (dcnt >= imu_decim) ? '0 : dcnt + D_ONE;
            end
            if (mode_chg) begin
                pcnt <= '0;
            end else if ((mode == MODE_FREE) && tick) begin
                pcnt <= ((free_period_usec == '0) || period_end) ? '0 : pcnt + P_ONE;
            end
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
        end else begin
            frame_start <= accept;
            if (accept) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (drop && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        trigger_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .c             (c),
            .rst_n         (rst_n),
            .start         (accept),
            .tick          (tick),
            .delay_usec    (delay_usec[i*CNT_W +: CNT_W]),
            .exposure_usec (exposure_usec[i*CNT_W +: CNT_W]),
            .flash_usec    (flash_usec[i*CNT_W +: CNT_W]),
            .trigger       (trigger[i]),
            .flash         (flash[i]),
            .busy          (chan_busy[i])
        );
    end

endmodule

// File: tb/tb_trigger_multi.sv
// tb/tb_trigger_multi.sv - scoreboard bench for trigger_multi with CLK_PER_USEC=4, NCH=2
module tb_trigger_multi;

    localparam int NCH   = 2;
    localparam int CPU   = 4;
    localparam int CNT_W = 16;

    typedef struct {
        int kind;
        int ofs;
        int width;
    } pulse_t;

    logic               c;
    logic               rst_n;
    logic               enable;
    logic               mode;
    logic               imu_sync;
    logic [7:0]         imu_decim;
    logic [CNT_W-1:0]   free_period_usec;
    logic [NCH*CNT_W-1:0] delay_usec;
    logic [NCH*CNT_W-1:0] exposure_usec;
    logic [NCH*CNT_W-1:0] flash_usec;
    logic [NCH-1:0]     trigger;
    logic [NCH-1:0]     flash;
    logic               frame_start;
    logic [15:0]        frame_cnt;
    logic [7:0]         overrun_cnt;
    logic               busy;

    logic [CNT_W-1:0] d_cfg [NCH];
    logic [CNT_W-1:0] e_cfg [NCH];
    logic [CNT_W-1:0] f_cfg [NCH];

    assign delay_usec    = {d_cfg[1], d_cfg[0]};
    assign exposure_usec = {e_cfg[1], e_cfg[0]};
    assign flash_usec    = {f_cfg[1], f_cfg[0]};

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          fs_cyc   = 0;
    logic [15:0] exp_frame = '0;
    logic [15:0] frame_q [$];
    pulse_t      exp_q [$];
    logic [3:0]  prev_lvl = '0;
    int          rise_cyc [4];
    int          rise_ofs [4];
    string       names [4] = '{"trig0", "trig1", "flash0", "flash1"};

    trigger_multi #(
        .NCH          (NCH),
        .CLK_PER_USEC (CPU),
        .CNT_W        (CNT_W),
        .DECIM_W      (8)
    ) dut (
        .c                (c),
        .rst_n            (rst_n),
        .enable           (enable),
        .mode             (mode),
        .imu_sync         (imu_sync),
        .imu_decim        (imu_decim),
        .free_period_usec (free_period_usec),
        .delay_usec       (delay_usec),
        .exposure_usec    (exposure_usec),
        .flash_usec       (flash_usec),
        .trigger          (trigger),
        .flash            (flash),
        .frame_start      (frame_start),
        .frame_cnt        (frame_cnt),
        .overrun_cnt      (overrun_cnt),
        .busy             (busy)
    );

    initial c = 1'b0;
    always #5 c = ~c;
    always @(posedge c) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge c);
        #1;
    endtask

    task automatic fire_sync();
        @(posedge c);
        #1 imu_sync = 1'b1;
        @(posedge c);
        #1 imu_sync = 1'b0;
    endtask

    task automatic set_cfg(input int ch, input int d, input int e, input int f);
        d_cfg[ch] = CNT_W'(d);
        e_cfg[ch] = CNT_W'(e);
        f_cfg[ch] = CNT_W'(f);
    endtask

    task automatic expect_frame();
        pulse_t pe;
        exp_frame++;
        frame_q.push_back(exp_frame);
        for (int i = 0; i < NCH; i++) begin
            if (e_cfg[i] != '0) begin
                pe.kind  = i;
                pe.ofs   = int'(d_cfg[i]) * CPU;
                pe.width = int'(e_cfg[i]) * CPU;
                exp_q.push_back(pe);
                if (f_cfg[i] != '0) begin
                    pe.kind  = i + 2;
                    pe.width = int'(f_cfg[i]) * CPU;
                    exp_q.push_back(pe);
                end
            end
        end
    endtask

    // Pulse offsets are measured from the frame_start cycle, widths in clock cycles.
    always @(negedge c) begin : mon
        logic [3:0] lvl;
        int         idx;
        if (!rst_n) begin
            prev_lvl = '0;
        end else begin
            if (frame_start) begin
                fs_cyc = cyc;
                check_eq("frame_expected", frame_q.size() > 0, 1);
                if (frame_q.size() > 0) check_eq("frame_cnt", frame_cnt, frame_q.pop_front());
            end
            lvl = {flash, trigger};
            for (int k = 0; k < 4; k++) begin
                if (lvl[k] && !prev_lvl[k]) begin
                    rise_cyc[k] = cyc;
                    rise_ofs[k] = cyc - fs_cyc;
                end else if (!lvl[k] && prev_lvl[k]) begin
                    idx = -1;
                    for (int j = 0; j < exp_q.size(); j++) begin
                        if (idx < 0 && exp_q[j].kind == k) idx = j;
                    end
                    check_eq({names[k], "_expected"}, idx >= 0, 1);
                    if (idx >= 0) begin
                        check_eq({names[k], "_ofs"}, rise_ofs[k], exp_q[idx].ofs);
                        check_eq({names[k], "_width"}, cyc - rise_cyc[k], exp_q[idx].width);
                        exp_q.delete(idx);
                    end
                end
            end
            prev_lvl = lvl;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int fsc [3];
        int nf;
        int ov0;

        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; imu_sync = 1'b0;
        imu_decim = '0; free_period_usec = '0;
        set_cfg(0, 0, 0, 0);
        set_cfg(1, 0, 0, 0);
        repeat (3) @(posedge c);
        @(negedge c);
        check_eq("rst_trigger", trigger, 0);
        check_eq("rst_flash", flash, 0);
        check_eq("rst_frame_start", frame_start, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_overrun", overrun_cnt, 0);
        check_eq("rst_busy", busy, 0);
        cyc_wait(1);
        rst_n = 1'b1;
        cyc_wait(2);

        // IMU decimation: frames on syncs 1, 4, 7
        set_cfg(0, 0, 1, 0);
        imu_decim = 8'd2;
        enable = 1'b1;
        cyc_wait(2);
        for (int k = 0; k < 9; k++) begin
            if (k % 3 == 0) expect_frame();
            fire_sync();
            cyc_wait(10);
        end
        @(negedge c);
        check_eq("imu_frame_cnt", frame_cnt, 3);

        // Two channels with delay and a flash that outlasts the trigger
        imu_decim = 8'd0;
        set_cfg(0, 0, 3, 0);
        set_cfg(1, 2, 1, 5);
        cyc_wait(2);
        expect_frame();
        fire_sync();
        cyc_wait(27);
        @(negedge c);
        check_eq("busy_at_n28", busy, 1);
        @(negedge c);
        check_eq("busy_at_n29", busy, 0);

        // Exposure changed mid-frame only affects the next frame
        set_cfg(0, 0, 3, 0);
        set_cfg(1, 0, 0, 0);
        cyc_wait(4);
        expect_frame();
        fire_sync();
        cyc_wait(2);
        e_cfg[0] = 16'd7;
        cyc_wait(20);
        expect_frame();
        fire_sync();
        cyc_wait(35);

        // Channel with zero exposure is skipped, flash included
        set_cfg(0, 0, 1, 0);
        set_cfg(1, 0, 0, 4);
        cyc_wait(2);
        expect_frame();
        fire_sync();
        cyc_wait(3);
        @(negedge c);
        check_eq("skip_busy_n4", busy, 1);
        @(negedge c);
        check_eq("skip_busy_n5", busy, 0);

        // Free-run: period 10 usec, exposure 19 usec -> every second raw event dropped
        set_cfg(0, 0, 19, 0);
        set_cfg(1, 0, 0, 0);
        free_period_usec = 16'd10;
        cyc_wait(2);
        for (int k = 0; k < 3; k++) expect_frame();
        @(negedge c);
        ov0 = int'(overrun_cnt);
        mode = 1'b1;
        nf = 0;
        for (int t = 0; t < 1000 && nf < 3; t++) begin
            @(negedge c);
            if (frame_start) begin
                fsc[nf] = cyc;
                nf++;
            end
        end
        enable = 1'b0;
        check_eq("free_frames", nf, 3);
        check_eq("free_spacing1", fsc[1] - fsc[0], 80);
        check_eq("free_spacing2", fsc[2] - fsc[1], 80);
        check_eq("free_overrun", int'(overrun_cnt) - ov0, 2);
        cyc_wait(100);

        // Overrun saturation: raw event every usec against a 300 usec exposure
        free_period_usec = 16'd1;
        set_cfg(0, 0, 300, 0);
        expect_frame();
        enable = 1'b1;
        cyc_wait(1100);
        enable = 1'b0;
        @(negedge c);
        check_eq("overrun_sat", overrun_cnt, 255);
        cyc_wait(150);

        // Reset in the middle of an exposure
        mode = 1'b0;
        imu_decim = 8'd3;
        set_cfg(0, 0, 10, 10);
        enable = 1'b1;
        cyc_wait(3);
        expect_frame();
        fire_sync();
        cyc_wait(10);
        check_eq("pre_rst_trigger", trigger, 1);
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_trigger", trigger, 0);
        check_eq("mid_rst_flash", flash, 0);
        check_eq("mid_rst_frame_start", frame_start, 0);
        check_eq("mid_rst_frame_cnt", frame_cnt, 0);
        check_eq("mid_rst_overrun", overrun_cnt, 0);
        check_eq("mid_rst_busy", busy, 0);
        exp_frame = '0;
        cyc_wait(3);
        rst_n = 1'b1;
        set_cfg(0, 0, 1, 0);
        cyc_wait(2);
        expect_frame();
        fire_sync();
        cyc_wait(10);
        @(negedge c);
        check_eq("post_rst_frame_cnt", frame_cnt, 1);

        cyc_wait(20);
        check_eq("scoreboard_empty", exp_q.size() + frame_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
